// File: rtl/i2s_capture_bram_if.sv
// BRAM write port and capture control bundle between i2s_capture_bram and the PS side.
// The master modport is the capture block; the slave modport is the BRAM/PS side.
interface i2s_capture_bram_if;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        start;
  logic        chan_sel;
  logic        busy;
  logic        done;
  logic        frame_err;

  modport master (
    output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
    input  BRAM_dout,
    input  start, chan_sel,
    output busy, done, frame_err
  );

  modport slave (
    input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
    output BRAM_dout,
    output start, chan_sel,
    input  busy, done, frame_err
  );
endinterface

// File: rtl/i2s_capture_bram.sv
// Captures CLIP_LEN samples of one I2S record channel into PS-shared BRAM,
// one sign-extended 32-bit word per sample; I2S pins are oversampled in the clk domain.
module i2s_capture_bram #(
  parameter int SAMPLE_BITS         = 16,
  parameter int CLIP_LEN            = 64,
  parameter int BRAM_ADDR_INCREMENT = 4,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  i2s_capture_bram_if.master   bus,
  input  logic                 audio_I2S_bclk,
  input  logic                 audio_I2S_reclrc,
  input  logic                 audio_I2S_recdat
);

  localparam int IDX_W = $clog2(CLIP_LEN + 1);
  localparam int BIT_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SAMPLE_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLIP_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [31:0] sign_extend(input logic signed [SAMPLE_BITS-1:0] s);
    return {{(32 - SAMPLE_BITS){s[SAMPLE_BITS-1]}}, s};
  endfunction

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrc_sync, r_dat_sync;
  logic                   r_bclk_prev;
  logic                   w_bclk, w_lrc, w_dat, w_rise;

  logic [2:0]             r_state;
  logic                   r_chan;
  logic                   r_lrc_prev;
  logic [IDX_W-1:0]       r_idx;
  logic [BIT_W-1:0]       r_bitcnt;
  logic [SAMPLE_BITS-2:0] r_shift;
  logic [SAMPLE_BITS-1:0] w_next;
  logic [31:0]            w_addr;
  logic [31:0]            r_addr, r_din;
  logic                   r_en;
  logic [3:0]             r_we;
  logic                   r_bram_rst;
  logic                   r_done, r_frame_err;
  logic                   w_unused_dout;

  // Input synchronizers and bclk rising-edge strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(audio_I2S_bclk);
      r_lrc_sync  <= (r_lrc_sync  << 1) | SYNC_STAGES'(audio_I2S_reclrc);
      r_dat_sync  <= (r_dat_sync  << 1) | SYNC_STAGES'(audio_I2S_recdat);
      r_bclk_prev <= w_bclk;
    end
  end

  assign w_bclk = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrc  = r_lrc_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];
  assign w_rise = w_bclk & ~r_bclk_prev;
  assign w_next = {r_shift, w_dat};
  assign w_addr = 32'(r_idx) * 32'(BRAM_ADDR_INCREMENT);

  // Capture FSM; BRAM strobes are registered so addr/din/we share one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_chan      <= 1'b0;
      r_lrc_prev  <= 1'b0;
      r_idx       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_en        <= 1'b0;
      r_we        <= 4'h0;
      r_bram_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_bram_rst <= 1'b0;
      if (w_rise) r_lrc_prev <= w_lrc;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_chan      <= bus.chan_sel;
            r_idx       <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          // LRC edge into the selected channel is the one-bit delay slot
          if (w_rise && (w_lrc != r_lrc_prev) && (w_lrc == r_chan)) begin
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_rise) begin
            // The last bit may legitimately coincide with the next LRC edge
            if ((w_lrc != r_lrc_prev) && (r_bitcnt != LAST_BIT)) begin
              r_frame_err <= 1'b1;
              r_state     <= S_SYNC;
            end else begin
              r_shift  <= w_next[SAMPLE_BITS-2:0];
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == LAST_BIT) begin
                r_en    <= 1'b1;
                r_we    <= 4'hF;
                r_addr  <= w_addr;
                r_din   <= sign_extend(w_next);
                r_state <= S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          r_en  <= 1'b0;
          r_we  <= 4'h0;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SYNC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_unused_dout = ^bus.BRAM_dout;

  assign bus.BRAM_clk  = clk;
  assign bus.BRAM_addr = r_addr;
  assign bus.BRAM_din  = r_din;
  assign bus.BRAM_en   = r_en;
  assign bus.BRAM_we   = r_we;
  assign bus.BRAM_rst  = r_bram_rst;
  assign bus.busy      = (r_state == S_SYNC) || (r_state == S_SHIFT) || (r_state == S_WRITE);
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_capture_bram.sv
// Directed bench for i2s_capture_bram: an I2S record source drives frames whose left
// word is 0x8000+frame number and right word is 0x1234; BRAM writes are logged and checked.
`timescale 1ns/1ps
module tb_i2s_capture_bram;

  logic clk = 1'b0;
  logic rst;
  logic i2s_bclk, i2s_lrc, i2s_dat;

  i2s_capture_bram_if bus();

  i2s_capture_bram #(
    .SAMPLE_BITS(16), .CLIP_LEN(64), .BRAM_ADDR_INCREMENT(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .audio_I2S_bclk(i2s_bclk), .audio_I2S_reclrc(i2s_lrc), .audio_I2S_recdat(i2s_dat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // I2S source controls
  int half_ns     = 40;
  int word_bclks  = 32;
  int frame_n     = 0;
  int short_frame = -1;

  task automatic send_word(input logic side, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      i2s_bclk = 1'b0;
      if (i == 0) i2s_lrc = side;
      i2s_dat = (i >= 1 && i <= 16) ? w[16 - i] : 1'b0;
      #(half_ns);
      i2s_bclk = 1'b1;
      #(half_ns);
    end
  endtask

  initial begin
    i2s_bclk = 1'b0; i2s_lrc = 1'b1; i2s_dat = 1'b0;
    #3;
    forever begin
      send_word(1'b0, 16'h8000 + 16'(frame_n), (frame_n == short_frame) ? 10 : word_bclks);
      send_word(1'b1, 16'h1234, word_bclks);
      frame_n++;
    end
  end

  // Write log and BRAM model
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [4:0]  wr_ctl[$];
  int          wr_cyc[$];
  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          done_cyc = -1;
  logic        done_q = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.BRAM_we != 4'h0 || bus.BRAM_en) begin
      wr_addr.push_back(bus.BRAM_addr);
      wr_data.push_back(bus.BRAM_din);
      wr_ctl.push_back({bus.BRAM_en, bus.BRAM_we});
      wr_cyc.push_back(cyc);
      if (bus.BRAM_we == 4'hF) mem[bus.BRAM_addr[7:2]] <= bus.BRAM_din;
    end
    if (bus.done === 1'b1 && !done_q) done_cyc = cyc;
    done_q = (bus.done === 1'b1);
  end

  function automatic logic [31:0] left_word(input int n);
    return 32'hFFFF8000 + 32'(n);
  endfunction

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_ctl.delete(); wr_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic wait_word(input logic side);
    int n = 0;
    while (i2s_lrc == side && n < 4000) begin @(negedge clk); n++; end
    while (i2s_lrc != side && n < 4000) begin @(negedge clk); n++; end
    n_assert++;
    if (n >= 4000) begin n_fail++; $display("FAIL wait_word timeout side=%0d", side); end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    n_assert++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wait_done timeout after %0d cycles, writes=%0d", n, wr_addr.size()); end
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int n = 0;
    while (wr_addr.size() < cnt && n < budget) begin @(negedge clk); n++; end
    n_assert++;
    if (wr_addr.size() < cnt) begin n_fail++; $display("FAIL wait_writes got %0d want %0d", wr_addr.size(), cnt); end
  endtask

  task automatic pulse_start(input logic ch);
    @(negedge clk);
    bus.chan_sel = ch;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++; if (bus.BRAM_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 00000000", bus.BRAM_addr); end
    n_assert++; if (bus.BRAM_din !== 32'h0) begin n_fail++; $display("FAIL reset_din got %h want 00000000", bus.BRAM_din); end
    n_assert++; if ({bus.BRAM_en, bus.BRAM_we} !== 5'h00) begin n_fail++; $display("FAIL reset_en_we got %b want 00000", {bus.BRAM_en, bus.BRAM_we}); end
    n_assert++; if (bus.BRAM_rst !== 1'b1) begin n_fail++; $display("FAIL reset_bram_rst got %b want 1", bus.BRAM_rst); end
    n_assert++; if ({bus.busy, bus.done, bus.frame_err} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b want 000", {bus.busy, bus.done, bus.frame_err}); end
    n_assert++; if (bus.BRAM_clk !== 1'b0) begin n_fail++; $display("FAIL bram_clk_low got %b want 0", bus.BRAM_clk); end
    rst = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.BRAM_rst !== 1'b0) begin n_fail++; $display("FAIL bram_rst_release got %b want 0", bus.BRAM_rst); end
    repeat (20) @(negedge clk);
    n_assert++; if (bus.busy !== 1'b0 || wr_addr.size() != 0) begin n_fail++; $display("FAIL idle_quiet busy=%b writes=%0d want 0/0", bus.busy, wr_addr.size()); end
  endtask

  task automatic test_basic();
    int base, k;
    clear_log();
    wait_word(1'b1);
    repeat (8) @(negedge clk);
    base = frame_n + 1;
    pulse_start(1'b0);
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    wait_done(40000);
    repeat (4) @(negedge clk);
    n_assert++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL basic_count got %0d want 64", wr_addr.size()); end
    for (k = 0; k < 64 && k < wr_addr.size(); k++) begin
      n_assert++; if (wr_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h want %h", k, wr_addr[k], 32'(4 * k)); end
      n_assert++; if (wr_data[k] !== left_word(base + k)) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", k, wr_data[k], left_word(base + k)); end
      n_assert++; if (wr_ctl[k] !== 5'h1F) begin n_fail++; $display("FAIL basic_en_we[%0d] got %b want 11111", k, wr_ctl[k]); end
    end
    if (wr_cyc.size() > 0) begin
      n_assert++; if (done_cyc != wr_cyc[wr_cyc.size() - 1] + 1) begin n_fail++; $display("FAIL basic_done_timing got cycle %0d want %0d", done_cyc, wr_cyc[wr_cyc.size() - 1] + 1); end
    end
    n_assert++; if ({bus.busy, bus.done, bus.frame_err} !== 3'b010) begin n_fail++; $display("FAIL basic_status got %b want 010", {bus.busy, bus.done, bus.frame_err}); end
  endtask

  task automatic test_midframe();
    int base, k;
    clear_log();
    wait_word(1'b0);
    repeat (24) @(negedge clk);
    base = frame_n + 1;
    pulse_start(1'b0);
    wait_writes(3, 2000);
    for (k = 0; k < 3 && k < wr_addr.size(); k++) begin
      n_assert++; if (wr_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL mid_addr[%0d] got %h want %h", k, wr_addr[k], 32'(4 * k)); end
      n_assert++; if (wr_data[k] !== left_word(base + k)) begin n_fail++; $display("FAIL mid_data[%0d] got %h want %h", k, wr_data[k], left_word(base + k)); end
    end
    reset_pulse();
  endtask

  task automatic test_short();
    int base, k;
    logic [31:0] exp;
    clear_log();
    wait_word(1'b1);
    repeat (8) @(negedge clk);
    base = frame_n + 1;
    short_frame = base + 2;
    pulse_start(1'b0);
    wait_done(12000);
    repeat (4) @(negedge clk);
    short_frame = -1;
    n_assert++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL short_count got %0d want 64", wr_addr.size()); end
    for (k = 0; k < 64 && k < wr_addr.size(); k++) begin
      exp = (k < 2) ? left_word(base + k) : left_word(base + k + 1);
      n_assert++; if (wr_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL short_addr[%0d] got %h want %h", k, wr_addr[k], 32'(4 * k)); end
      n_assert++; if (wr_data[k] !== exp) begin n_fail++; $display("FAIL short_data[%0d] got %h want %h", k, wr_data[k], exp); end
    end
    n_assert++; if ({bus.done, bus.frame_err} !== 2'b11) begin n_fail++; $display("FAIL short_status done/frame_err got %b want 11", {bus.done, bus.frame_err}); end
  endtask

  task automatic test_reset_mid();
    int base, n20;
    clear_log();
    wait_word(1'b1);
    repeat (8) @(negedge clk);
    pulse_start(1'b0);
    n_assert++; if ({bus.done, bus.frame_err} !== 2'b00) begin n_fail++; $display("FAIL rearm_clear done/frame_err got %b want 00", {bus.done, bus.frame_err}); end
    wait_writes(20, 4000);
    rst = 1'b1;
    #1;
    n_assert++; if ({bus.BRAM_en, bus.BRAM_we, bus.busy, bus.done} !== 7'h00) begin n_fail++; $display("FAIL rstmid_ctl got %b want 0000000", {bus.BRAM_en, bus.BRAM_we, bus.busy, bus.done}); end
    n_assert++; if (bus.BRAM_addr !== 32'h0 || bus.BRAM_din !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus addr=%h din=%h want 0/0", bus.BRAM_addr, bus.BRAM_din); end
    n_assert++; if (bus.BRAM_rst !== 1'b1) begin n_fail++; $display("FAIL rstmid_bram_rst got %b want 1", bus.BRAM_rst); end
    n20 = wr_addr.size();
    repeat (150) @(negedge clk);
    n_assert++; if (wr_addr.size() != n20) begin n_fail++; $display("FAIL rstmid_nowrite got %0d want %0d", wr_addr.size(), n20); end
    rst = 1'b0;
    clear_log();
    wait_word(1'b1);
    repeat (8) @(negedge clk);
    base = frame_n + 1;
    pulse_start(1'b0);
    wait_writes(2, 2000);
    if (wr_addr.size() >= 2) begin
      n_assert++; if (wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4) begin n_fail++; $display("FAIL rstmid_restart_addr got %h,%h want 00000000,00000004", wr_addr[0], wr_addr[1]); end
      n_assert++; if (wr_data[0] !== left_word(base)) begin n_fail++; $display("FAIL rstmid_restart_data got %h want %h", wr_data[0], left_word(base)); end
    end
    reset_pulse();
  endtask

  task automatic test_busy_rearm();
    int base, k;
    clear_log();
    wait_word(1'b1);
    repeat (8) @(negedge clk);
    base = frame_n + 1;
    pulse_start(1'b0);
    wait_writes(5, 2000);
    pulse_start(1'b1);
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignored_start busy got %b want 1", bus.busy); end
    wait_done(12000);
    repeat (4) @(negedge clk);
    n_assert++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL busy_count got %0d want 64", wr_addr.size()); end
    for (k = 0; k < 64 && k < wr_addr.size(); k++) begin
      n_assert++; if (wr_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL busy_addr[%0d] got %h want %h", k, wr_addr[k], 32'(4 * k)); end
      n_assert++; if (wr_data[k] !== left_word(base + k)) begin n_fail++; $display("FAIL busy_data[%0d] got %h want %h", k, wr_data[k], left_word(base + k)); end
    end
    clear_log();
    wait_word(1'b0);
    repeat (8) @(negedge clk);
    pulse_start(1'b1);
    n_assert++; if ({bus.busy, bus.done} !== 2'b10) begin n_fail++; $display("FAIL rearm_done_busy got %b want 10", {bus.busy, bus.done}); end
    wait_done(12000);
    repeat (4) @(negedge clk);
    n_assert++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL right_count got %0d want 64", wr_addr.size()); end
    for (k = 0; k < 64 && k < wr_addr.size(); k++) begin
      n_assert++; if (wr_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL right_addr[%0d] got %h want %h", k, wr_addr[k], 32'(4 * k)); end
      n_assert++; if (wr_data[k] !== 32'h00001234) begin n_fail++; $display("FAIL right_data[%0d] got %h want 00001234", k, wr_data[k]); end
    end
    n_assert++; if (mem[0] !== 32'h00001234 || mem[63] !== 32'h00001234) begin n_fail++; $display("FAIL right_overwrite mem0=%h mem63=%h want 00001234", mem[0], mem[63]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.chan_sel = 1'b0;
    bus.BRAM_dout = 32'h0;
    test_reset();
    test_basic();
    half_ns = 20;
    word_bclks = 17;
    test_midframe();
    test_short();
    test_reset_mid();
    test_busy_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_capture_bram.md
# i2s_capture_bram

Receive-side counterpart of the BRAM-fed I2S playback path. Deserializes codec record data (`audio_I2S_recdat`) in standard I2S format, extracts one selected channel, and writes `CLIP_LEN` consecutive samples into the PS-shared BRAM, one 32-bit word per sample. The I2S clocks arrive asynchronously and are oversampled in the `clk` domain. The PS reads the BRAM after `done`.

## Interface
- `SAMPLE_BITS`, 16: captured bits per sample, MSB first.
- `CLIP_LEN`, 64: samples per capture.
- `BRAM_ADDR_INCREMENT`, 4: byte address step per word.
- `SYNC_STAGES`, 2: synchronizer depth for the I2S inputs.

Ports:
- `clk` in 1: system clock; `BRAM_clk` is driven from it.
- `rst` in 1: asynchronous, active-high reset.
- `BRAM_addr` out 32: byte address.
- `BRAM_clk` out 1: equals `clk`.
- `BRAM_din` out 32: write data.
- `BRAM_dout` in 32: unused; present for port parity.
- `BRAM_en` out 1: BRAM enable.
- `BRAM_rst` out 1: BRAM reset.
- `BRAM_we` out 4: byte write enables.
- `start` in 1: one-cycle pulse that arms a capture.
- `chan_sel` in 1: 0 = left (LRC low), 1 = right (LRC high). Sampled on `start`.
- `busy` out 1: capture in progress.
- `done` out 1: capture complete; held until the next accepted `start`.
- `frame_err` out 1: sticky; a short channel word was seen. Cleared on an accepted `start`.
- `audio_I2S_bclk` in 1: bit clock, asynchronous.
- `audio_I2S_reclrc` in 1: record word select, asynchronous.
- `audio_I2S_recdat` in 1: record data, asynchronous.

## Operation
- **Synchronization:** `bclk`, `reclrc` and `recdat` each pass through `SYNC_STAGES` flops. A bclk rising edge is detected when the synchronized value is 1 and was 0 on the previous cycle; this produces a one-cycle `rise` strobe. `reclrc` and `recdat` are sampled only on `rise`.
- **Requirement:** the `clk` frequency must be at least 4× the bclk frequency.
- **State machine:** IDLE, SYNC, SHIFT, WRITE, DONE.
  - **IDLE:** `BRAM_en`=0. On `start`, latch `chan_sel`, clear index, `frame_err` and `done`, then go to SYNC.
  - **SYNC:** on a `rise` where the sampled LRC differs from the previously sampled LRC and now equals the selected channel, go to SHIFT. That edge is the I2S one-bit delay slot; no data is taken on it. Bit counter = 0.
  - **SHIFT:** on each `rise`, shift `recdat` into the MSB-first shift register and increment the bit counter.
    - When the counter reaches `SAMPLE_BITS`, go to WRITE. Bits beyond `SAMPLE_BITS` in the channel word are ignored.
    - If LRC changes before `SAMPLE_BITS` bits are collected: set `frame_err`, discard the partial sample, return to SYNC. The index is unchanged.
  - **WRITE:** one cycle with `BRAM_en`=1 and `BRAM_we`=4'hF.
    - `BRAM_addr` = index×`BRAM_ADDR_INCREMENT`.
    - `BRAM_din` = sample sign-extended to 32 bits.
    - Then index+1. If the new index equals `CLIP_LEN`, go to DONE; otherwise go to SYNC and wait for the next frame of the selected channel.
  - **DONE:** `BRAM_en`=0, `BRAM_we`=0, `done`=1. On `start`, re-arm exactly as from IDLE.
- `busy` = 1 in SYNC, SHIFT and WRITE.
- `start` is ignored while `busy`=1.
- Addresses run 0 … 4×(`CLIP_LEN`−1). There is no wrap; the block stops at `CLIP_LEN`.
- **Reset mid-capture:** all state is cleared immediately, with no partial write. The BRAM keeps whatever words were already written.

## Timing
- **Reset values:**
  - `BRAM_addr`=0, `BRAM_din`=0, `BRAM_en`=0, `BRAM_we`=0.
  - `BRAM_rst`=1; it goes to 0 on the first `clk` edge after reset release.
  - `busy`=0, `done`=0, `frame_err`=0.
  - State = IDLE.
- **Edge detection:** `rise` occurs `SYNC_STAGES`+1 clk after the pin edge.
- **Write timing:** WRITE is the clk cycle immediately after the `rise` that captured bit `SAMPLE_BITS`−1. The write strobe is exactly one cycle wide. `BRAM_addr` and `BRAM_din` are valid in the same cycle as `BRAM_we`.
- **Done timing:** `done` rises on the clk after the final WRITE cycle.
- **`start` vs. `rise`:** if `start` and a `rise` coincide, `start` is accepted and that `rise` is not used for frame detection.

## Test plan
- **Basic capture:** bclk = clk/8, 32 bclk per channel. Left words = 0x8000+n, right words = 0x1234. `chan_sel`=0, `start` → BRAM words 0…63 = 0xFFFF8000+n (sign-extended); 64 single-cycle writes at addresses 0,4,…,252; then `done`=1, `busy`=0.
- **Right channel:** same stimulus, `chan_sel`=1 → all 64 words = 0x00001234; left data is never written.
- **Arming mid-frame:** assert `start` in the middle of a left word → the first write is the next complete left word; the partial word is never written.
- **Short frame:** one left word only 10 bclk long → `frame_err`=1, no write for that frame. The next full word goes to the same index, and the capture still completes with 64 words.
- **Reset mid-capture:** assert `rst` after 20 writes → outputs return to reset values within the same cycle; a new `start` captures from address 0.
- **Busy and re-arm:** pulse `start` while `busy`=1 → ignored, with no address jump. Pulse `start` in DONE → `done` clears and a second capture overwrites addresses 0…252.
